// File: rtl/nuc970_ecc_check_if.sv
// Beat-stream bus for the BCH codeword checker: the source drives beats, the checker returns status.
// The optional err_count field exists only when NUC970_ECC_CHECK_ERR_COUNT_EN is defined.
interface nuc970_ecc_check_if #(
  parameter int BITS = 8,
  parameter int R    = 52
);
  logic            ce;
  logic            start;
  logic [BITS-1:0] data_in;
  logic            ready;
  logic            done;
  logic            err;
  logic [R-1:0]    remainder;
`ifdef NUC970_ECC_CHECK_ERR_COUNT_EN
  logic [15:0]     err_count;

  modport master (output ce, start, data_in,
                  input  ready, done, err, remainder, err_count);
  modport slave  (input  ce, start, data_in,
                  output ready, done, err, remainder, err_count);
`else
  modport master (output ce, start, data_in,
                  input  ready, done, err, remainder);
  modport slave  (input  ce, start, data_in,
                  output ready, done, err, remainder);
`endif
endinterface

// File: rtl/nuc970_ecc_check.sv
// Receive-side BCH checker: re-encodes the data beats and XORs the result with the received parity.
// Optional feature macro NUC970_ECC_CHECK_ERR_COUNT_EN adds a saturating 16-bit error-frame counter.
module nuc970_ecc_check #(
  parameter int T         = 4,
  parameter int M         = 13,
  parameter int DATA_BITS = 4288,
  parameter int BITS      = 8,
  parameter logic [M*T-1:0] GEN_POLY = '0
) (
  input  logic              clk_in,
  input  logic              rst_n,
  nuc970_ecc_check_if.slave bus
);
  localparam int R          = M * T;
  localparam int ECC_BYTES  = (R + BITS - 1) / BITS;
  localparam int DATA_BEATS = DATA_BITS / BITS;
  localparam int PAR_W      = ECC_BYTES * BITS;
  localparam int CNT_W      = $clog2(DATA_BEATS + ECC_BYTES);

  // state | meaning
  // IDLE  | waiting for ce&start
  // DATA  | absorbing data beats into the LFSR
  // ECC   | LFSR frozen, collecting received parity beats
  // DONE  | result just produced (done pulse cycle)
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] ECC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [R-1:0]         lfsr_q, lfsr_d;
  logic [PAR_W-BITS-1:0] rx_q, rx_d;
  logic [R-1:0]         rem_q, rem_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic [PAR_W-1:0]     par_full;

  function automatic logic [R-1:0] fold(input logic [R-1:0] s_in, input logic [BITS-1:0] b);
    logic [R-1:0] s;
    logic         fb;
    s = s_in;
    for (int i = BITS - 1; i >= 0; i--) begin
      fb = b[i] ^ s[R-1];
      s  = {s[R-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
    end
    return s;
  endfunction

  // Final ECC beat is included here so the result registers in the same edge that accepts it.
  assign par_full = {rx_q, bus.data_in};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    rx_d    = rx_q;
    rem_d   = rem_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (state_q == DONE) state_d = IDLE;
    if (bus.ce) begin
      if (bus.start) begin
        lfsr_d  = fold('0, bus.data_in);
        cnt_d   = CNT_W'(1);
        rx_d    = '0;
        state_d = (DATA_BEATS == 1) ? ECC : DATA;
      end else begin
        case (state_q)
          DATA: begin
            lfsr_d = fold(lfsr_q, bus.data_in);
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_BEATS - 1)) state_d = ECC;
          end
          ECC: begin
            rx_d  = par_full[PAR_W-BITS-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_BEATS + ECC_BYTES - 1)) begin
              rem_d   = lfsr_q ^ par_full[PAR_W-1 -: R];
              err_d   = |rem_d;
              done_d  = 1'b1;
              cnt_d   = '0;
              state_d = DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= '0;
      rx_q    <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      rx_q    <= rx_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready     = (state_q == IDLE) || (state_q == DONE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.remainder = rem_q;

`ifdef NUC970_ECC_CHECK_ERR_COUNT_EN
  logic [15:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (done_d && err_d && (ecnt_q != 16'hFFFF)) ecnt_d = ecnt_q + 16'd1;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) ecnt_q <= '0;
    else        ecnt_q <= ecnt_d;
  end

  assign bus.err_count = ecnt_q;
`endif
endmodule

// File: tb/tb_nuc970_ecc_check.sv
// Self-checking bench for nuc970_ecc_check: frame-level model using polynomial long division.
module tb_nuc970_ecc_check;
  localparam int R         = 52;
  localparam int BITS      = 8;
  localparam int DATA_BITS = 4288;
  localparam int DB        = DATA_BITS / BITS;
  localparam int EB        = 7;
  localparam int NB        = DB + EB;
  localparam logic [R-1:0] GP = 52'h9A3F1C5BE270D;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  nuc970_ecc_check_if #(.BITS(BITS), .R(R)) bus();

  nuc970_ecc_check #(
    .T(4), .M(13), .DATA_BITS(DATA_BITS), .BITS(BITS), .GEN_POLY(GP)
  ) dut (
    .clk_in(clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;
  bit checking = 1'b0;

  logic [7:0] fr   [0:NB-1];
  logic [7:0] sb   [0:NB-1];
  logic [7:0] m_arr[0:NB-1];
  int         m_cnt    = 0;
  bit         in_frame = 1'b0;
  logic         exp_ready = 1'b1;
  logic         exp_done  = 1'b0;
  logic         exp_err   = 1'b0;
  logic [R-1:0] exp_rem   = '0;
  logic [15:0]  exp_ec    = '0;

  // Parity = (M(x) * x^R) mod G(x), by schoolbook long division over the data bits.
  function automatic logic [R-1:0] bch_par(input logic [7:0] bytes [0:NB-1]);
    bit d [0:DATA_BITS+R-1];
    logic [R-1:0] p;
    for (int k = 0; k < DATA_BITS + R; k++)
      d[k] = (k < DATA_BITS) ? bytes[k/8][7 - (k % 8)] : 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (d[i]) begin
        d[i] = 1'b0;
        for (int j = 1; j <= R; j++) d[i+j] = d[i+j] ^ GP[R-j];
      end
    end
    for (int j = 0; j < R; j++) p[R-1-j] = d[DATA_BITS+j];
    return p;
  endfunction

  function automatic logic [R-1:0] rx_top(input logic [7:0] bytes [0:NB-1]);
    logic [EB*8-1:0] f;
    f = '0;
    for (int k = 0; k < EB; k++) f = (f << 8) | (EB*8)'(bytes[DB+k]);
    return f[EB*8-1 -: R];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame  = 1'b0;
      m_cnt     = 0;
      exp_ready = 1'b1;
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      exp_rem   = '0;
      exp_ec    = '0;
    end else begin
      exp_done = 1'b0;
      if (bus.ce) begin
        if (bus.start) begin
          m_arr[0] = bus.data_in;
          m_cnt    = 1;
          in_frame = 1'b1;
        end else if (in_frame) begin
          m_arr[m_cnt] = bus.data_in;
          m_cnt++;
          if (m_cnt == NB) begin
            exp_rem  = bch_par(m_arr) ^ rx_top(m_arr);
            exp_err  = |exp_rem;
            exp_done = 1'b1;
            in_frame = 1'b0;
            if (exp_err && exp_ec != 16'hFFFF) exp_ec++;
          end
        end
      end
      exp_ready = !in_frame;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      if (bus.done === 1'b1) n_done++;
      n_assert++;
      if ({bus.ready, bus.done, bus.err} !== {exp_ready, exp_done, exp_err} ||
          bus.remainder !== exp_rem) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t: ready/done/err=%b%b%b rem=%h, expected %b%b%b rem=%h",
                 $time, bus.ready, bus.done, bus.err, bus.remainder,
                 exp_ready, exp_done, exp_err, exp_rem);
      end
`ifdef NUC970_ECC_CHECK_ERR_COUNT_EN
      n_assert++;
      if (bus.err_count !== exp_ec) begin
        n_fail++;
        $display("FAIL cycle_err_count t=%0t: got %0d expected %0d", $time, bus.err_count, exp_ec);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic beat(input logic st, input logic [7:0] b);
    bus.ce = 1'b1; bus.start = st; bus.data_in = b;
    @(posedge clk); #1;
    bus.ce = 1'b0; bus.start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input bit stall, input int upto);
    for (int i = 0; i < upto; i++) begin
      if (stall && i > 0) idle(1);
      beat(i == 0, fr[i]);
    end
  endtask

  task automatic build(input int kind);
    logic [R-1:0]    p;
    logic [EB*8-1:0] e;
    for (int i = 0; i < NB; i++) fr[i] = 8'h00;
    if (kind == 1) for (int i = 24; i < DB; i++) fr[i] = 8'hFF;
    p = bch_par(fr);
    e = {p, 4'b0000};
    for (int k = 0; k < EB; k++) fr[DB+k] = e[EB*8-1-8*k -: 8];
  endtask

  initial begin
    int d0;
    bus.ce = 1'b0; bus.start = 1'b0; bus.data_in = '0;
    #1 rst_n = 1'b0;
    #1 checking = 1'b1;
    #2;
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rem", bus.remainder, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    beat(1'b0, 8'hA5);
    idle(2);

    // 1: all-zero frame
    build(0); d0 = n_done;
    send(1'b0, NB);
    chk("t1_done_latency", bus.done, 1);
    idle(2);
    chk("t1_done_count", n_done - d0, 1);
    chk("t1_err", bus.err, 0);
    chk("t1_rem", bus.remainder, 0);

    // 2: 0xFF data bytes 24..535 with encoder parity
    build(1);
    chk("model_par_nonzero", (bch_par(fr) != '0), 1);
    send(1'b0, NB);
    chk("t2_done_latency", bus.done, 1);
    idle(2);
    chk("t2_err", bus.err, 0);
    chk("t2_rem", bus.remainder, 0);

    // 3: ECC byte 0 bit 7 flipped
    fr[DB][7] = ~fr[DB][7];
    send(1'b0, NB);
    idle(2);
    chk("t3_err", bus.err, 1);
    chk("t3_rem", bus.remainder, 64'h0008_0000_0000_0000);

    // 4: data byte 100 bit 0 flipped, parity of clean frame kept
    build(1);
    fr[100][0] = ~fr[100][0];
    send(1'b0, NB);
    idle(2);
    for (int i = 0; i < NB; i++) sb[i] = 8'h00;
    sb[100] = 8'h01;
    chk("t4_err", bus.err, 1);
    chk("t4_rem_nonzero", (bus.remainder != '0), 1);
    chk("t4_rem_single_bit", bus.remainder, bch_par(sb));
`ifdef NUC970_ECC_CHECK_ERR_COUNT_EN
    chk("err_count_after_t4", bus.err_count, 2);
`endif

    // 6: abort at data beat 200 with a new all-zero frame
    build(1); d0 = n_done;
    send(1'b0, 200);
    chk("t6_ready_mid", bus.ready, 0);
    build(0);
    send(1'b0, NB);
    idle(2);
    chk("t6_done_count", n_done - d0, 1);
    chk("t6_err", bus.err, 0);
    chk("t6_rem", bus.remainder, 0);

    // 5: ce toggled every cycle on frame 2
    build(1); d0 = n_done;
    send(1'b1, NB);
    chk("t5_done_latency", bus.done, 1);
    idle(2);
    chk("t5_done_count", n_done - d0, 1);
    chk("t5_err", bus.err, 0);
    chk("t5_rem", bus.remainder, 0);

    // reset mid-ECC after an erroneous frame
    build(1);
    fr[DB][7] = ~fr[DB][7];
    send(1'b0, NB);
    idle(2);
    chk("pre_rst_err", bus.err, 1);
    build(1);
    send(1'b0, DB + 3);
    rst_n = 1'b0;
    #2;
    chk("midrst_ready", bus.ready, 1);
    chk("midrst_done", bus.done, 0);
    chk("midrst_err", bus.err, 0);
    chk("midrst_rem", bus.remainder, 0);
`ifdef NUC970_ECC_CHECK_ERR_COUNT_EN
    chk("midrst_err_count", bus.err_count, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);
    build(1); d0 = n_done;
    send(1'b0, NB);
    idle(2);
    chk("post_rst_done_count", n_done - d0, 1);
    chk("post_rst_err", bus.err, 0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
